// File: rtl/wb_slave_mem_resp.sv
// Wishbone classic-cycle slave: word RAM with byte lanes, programmable wait
// states, forced retry and ERR on decode miss. All outputs are registered.
module wb_slave_mem_resp #(
  parameter int                DW        = 32,
  parameter int                AW        = 32,
  parameter int                MEM_AW    = 10,
  parameter logic [AW-1:0]     BASE_ADDR = 32'h0000_0000,
  parameter logic [AW-1:0]     ADDR_MASK = 32'hFFFF_F000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  input  logic [3:0]    sel_i,
  input  logic          we_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  output logic          ack_o,
  output logic          err_o,
  output logic          rty_o,
  input  logic [3:0]    wait_i,
  input  logic          rty_req_i,
  output logic          busy_o
);

  // Handshake: a request is accepted on any edge in IDLE with cyc_i & stb_i;
  // exactly one termination strobe follows for one cycle unless cyc_i drops
  // during WAIT, which abandons the request silently.
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {R_ACK, R_ERR, R_RTY} resp_t;

  state_t              state;
  logic   [3:0]        cnt;
  logic   [MEM_AW-1:0] idx_q;
  logic                we_q;
  logic   [3:0]        sel_q;
  logic   [DW-1:0]     dat_q;
  resp_t               resp_q;

  logic [DW-1:0] mem [0:(1<<MEM_AW)-1];

  logic                accept;
  logic                enter_resp;
  resp_t               in_type;
  resp_t               e_type;
  logic   [MEM_AW-1:0] e_idx;
  logic                e_we;
  logic   [3:0]        e_sel;
  logic   [DW-1:0]     e_dat;

  always_comb begin
    accept     = (state == IDLE) && cyc_i && stb_i;
    if ((adr_i & ADDR_MASK) != BASE_ADDR) in_type = R_ERR;
    else if (rty_req_i)                   in_type = R_RTY;
    else                                  in_type = R_ACK;
    enter_resp = (accept && (wait_i == 4'd0)) ||
                 ((state == WAIT) && cyc_i && (cnt == 4'd1));
    // On a zero-wait accept the live bus values feed the response edge directly.
    if (state == IDLE) begin
      e_type = in_type;
      e_idx  = adr_i[MEM_AW+1:2];
      e_we   = we_i;
      e_sel  = sel_i;
      e_dat  = dat_i;
    end else begin
      e_type = resp_q;
      e_idx  = idx_q;
      e_we   = we_q;
      e_sel  = sel_q;
      e_dat  = dat_q;
    end
  end

  // RAM is not reset; writes commit on the edge that enters RESP.
  always_ff @(posedge clk_i) begin
    if (enter_resp && (e_type == R_ACK) && e_we) begin
      for (int b = 0; b < 4; b++) begin
        if (e_sel[b]) mem[e_idx][8*b +: 8] <= e_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= 4'd0;
      dat_q  <= '0;
      resp_q <= R_ACK;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      rty_o  <= 1'b0;
      busy_o <= 1'b0;
      dat_o  <= '0;
    end else begin
      ack_o <= enter_resp && (e_type == R_ACK);
      err_o <= enter_resp && (e_type == R_ERR);
      rty_o <= enter_resp && (e_type == R_RTY);
      dat_o <= (enter_resp && (e_type == R_ACK) && !e_we) ? mem[e_idx] : '0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q  <= adr_i[MEM_AW+1:2];
            we_q   <= we_i;
            sel_q  <= sel_i;
            dat_q  <= dat_i;
            resp_q <= in_type;
            busy_o <= 1'b1;
            if (wait_i == 4'd0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= wait_i;
            end
          end
        end
        WAIT: begin
          if (!cyc_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy_o <= 1'b0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mem_resp.sv
// Directed bench for wb_slave_mem_resp: writes, byte lanes, wait states,
// decode miss, forced retry, cycle abort and asynchronous reset.
module tb_wb_slave_mem_resp;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel_i = '0;
  logic        we_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;
  logic [3:0]  wait_i = '0;
  logic        rty_req_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] T_ACK = 3'b001;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b100;

  wb_slave_mem_resp dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .sel_i(sel_i), .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o), .wait_i(wait_i), .rty_req_i(rty_req_i),
    .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request: drive, wait for termination (bounded), return what was seen.
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input logic [3:0] wt, input logic rty,
                      output logic [2:0] term, output logic [31:0] rdata, output int lat);
    adr_i = adr; dat_i = dat; sel_i = sel; we_i = we; wait_i = wt; rty_req_i = rty;
    cyc_i = 1'b1; stb_i = 1'b1;
    term = '0; rdata = '0; lat = -1;
    tick();
    for (int n = 0; n < 40 && lat < 0; n++) begin
      chk("busy_during", {31'd0, busy_o}, 32'd1);
      if (ack_o | err_o | rty_o) begin
        term  = {rty_o, err_o, ack_o};
        rdata = dat_o;
        lat   = n;
      end else begin
        wait_i = 4'd0;
        tick();
      end
    end
    chk("term_seen", {31'd0, lat >= 0}, 32'd1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; rty_req_i = 1'b0; wait_i = 4'd0;
    tick();
    chk("idle_after", {28'd0, busy_o, ack_o, err_o, rty_o}, 32'd0);
    chk("dat_after", dat_o, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [2:0] t; logic [31:0] d; int l;
    xfer(adr, dat, sel, 1'b1, 4'd0, 1'b0, t, d, l);
    chk("wr_term", {29'd0, t}, {29'd0, T_ACK});
    chk("wr_lat", l, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [2:0] t; logic [31:0] d; int l;
    xfer(adr, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0, 1'b0, t, d, l);
    chk("rd_term", {29'd0, t}, {29'd0, T_ACK});
    chk(tag, d, exp);
  endtask

  logic [2:0]  t;
  logic [31:0] d;
  int          l;

  initial begin
    repeat (3) tick();
    chk("reset_outs", {28'd0, busy_o, ack_o, err_o, rty_o}, 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("post_reset_outs", {28'd0, busy_o, ack_o, err_o, rty_o}, 32'd0);

    // 1: zero-wait write then read
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    rd("t1_read", 32'h10, 32'hDEAD_BEEF);

    // 2: byte-lane merge; read with sel=0 still returns all lanes
    wr(32'h20, 32'h1122_3344, 4'hF);
    wr(32'h20, 32'hAABB_CCDD, 4'b0010);
    rd("t2_read", 32'h20, 32'h1122_CC44);
    xfer(32'h20, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, t, d, l);
    chk("t2_sel0_read", d, 32'h1122_CC44);

    // 3: three wait states
    xfer(32'h10, 32'h0, 4'hF, 1'b0, 4'd3, 1'b0, t, d, l);
    chk("t3_term", {29'd0, t}, {29'd0, T_ACK});
    chk("t3_lat", l, 32'd3);
    chk("t3_data", d, 32'hDEAD_BEEF);

    // maximum wait count
    xfer(32'h20, 32'h0, 4'hF, 1'b0, 4'd15, 1'b0, t, d, l);
    chk("w15_lat", l, 32'd15);
    chk("w15_data", d, 32'h1122_CC44);

    // 4: window miss aliases word 0 in the index bits but must not write
    wr(32'h0, 32'h1234_5678, 4'hF);
    xfer(32'h0000_2000, 32'h55, 4'hF, 1'b1, 4'd0, 1'b0, t, d, l);
    chk("t4_term", {29'd0, t}, {29'd0, T_ERR});
    rd("t4_readback", 32'h0, 32'h1234_5678);
    // miss wins over a retry request
    xfer(32'h0000_2000, 32'h0, 4'hF, 1'b0, 4'd2, 1'b1, t, d, l);
    chk("t4_err_over_rty", {29'd0, t}, {29'd0, T_ERR});
    chk("t4_err_lat", l, 32'd2);

    // 5: forced retry, then real write
    wr(32'h30, 32'hCAFE_0000, 4'hF);
    xfer(32'h30, 32'h77, 4'hF, 1'b1, 4'd0, 1'b1, t, d, l);
    chk("t5_term", {29'd0, t}, {29'd0, T_RTY});
    chk("t5_rty_data", d, 32'h0);
    rd("t5_no_write", 32'h30, 32'hCAFE_0000);
    wr(32'h30, 32'h77, 4'hF);
    rd("t5_readback", 32'h30, 32'h77);

    // 6a: cycle dropped mid-WAIT
    wr(32'h40, 32'h1111, 4'hF);
    adr_i = 32'h40; dat_i = 32'h99; sel_i = 4'hF; we_i = 1'b1; wait_i = 4'd5;
    cyc_i = 1'b1; stb_i = 1'b1;
    tick();
    chk("t6_busy_rise", {31'd0, busy_o}, 32'd1);
    tick();
    tick();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; wait_i = 4'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_abort_outs", {28'd0, busy_o, ack_o, err_o, rty_o}, 32'd0);
    end
    rd("t6_abort_word", 32'h40, 32'h1111);

    // 6b: asynchronous reset mid-WAIT
    adr_i = 32'h40; dat_i = 32'h99; sel_i = 4'hF; we_i = 1'b1; wait_i = 4'd5;
    cyc_i = 1'b1; stb_i = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_busy_pre_rst", {31'd0, busy_o}, 32'd1);
    #2 rst_i = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; wait_i = 4'd0;
    #1;
    chk("t6_async_rst_outs", {28'd0, busy_o, ack_o, err_o, rty_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_post_rst_outs", {28'd0, busy_o, ack_o, err_o, rty_o}, 32'd0);
    end
    rd("t6_rst_word", 32'h40, 32'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
